// File: rtl/vx_ram_fifo_if.sv
// Valid/ready bundle for vx_ram_fifo: push side, pop side and occupancy status.
interface vx_ram_fifo_if #(
  parameter int DATAW = 32,
  parameter int CNTW  = 5
);
  logic             push_valid;
  logic [DATAW-1:0] push_data;
  logic             push_ready;
  logic             pop_valid;
  logic [DATAW-1:0] pop_data;
  logic             pop_ready;
  logic [CNTW-1:0]  count;
  logic             empty;
  logic             full;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count, empty, full
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count, empty, full
  );
endinterface

// File: rtl/vx_ram_fifo.sv
// Deep FIFO built on a dual-port RAM with registered read; a 2-entry output
// buffer hides the read latency so one transfer per cycle is sustained.
module vx_ram_fifo #(
  parameter int DATAW = 32,
  parameter int DEPTH = 16,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int CNTW  = $clog2(DEPTH + 3)
) (
  input  logic         clk,
  input  logic         reset_n,
  vx_ram_fifo_if.slave bus
);
  localparam logic [ADDRW:0]  RAM_FULL  = (ADDRW + 1)'(DEPTH);
  localparam logic [CNTW-1:0] COUNT_MAX = CNTW'(DEPTH + 2);

  logic [DATAW-1:0] ram_mem [DEPTH];
  logic [DATAW-1:0] ram_rd_data_reg;

  logic [ADDRW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDRW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDRW:0]   ram_cnt_reg, ram_cnt_next;
  logic             rd_inflight_reg, rd_inflight_next;
  logic [1:0]       ob_cnt_reg, ob_cnt_next;
  logic [DATAW-1:0] ob_data_reg [2];
  logic [DATAW-1:0] ob_data_next [2];
  logic [CNTW-1:0]  count_reg, count_next;

  logic       ram_has_room;
  logic       ob_has_data;
  logic       push_fire;
  logic       pop_fire;
  logic       issue;
  logic [2:0] ob_demand;
  logic       ob_wr_slot;

  // push_ready depends only on registered RAM occupancy, never on pop_ready.
  assign ram_has_room = (ram_cnt_reg != RAM_FULL);
  assign ob_has_data  = (ob_cnt_reg != 2'd0);
  assign push_fire    = bus.push_valid && ram_has_room;
  assign pop_fire     = bus.pop_ready && ob_has_data;

  // Entries the output buffer will hold once the pending read lands, after this pop.
  assign ob_demand  = 3'(ob_cnt_reg) + 3'(rd_inflight_reg) - 3'(pop_fire);
  assign issue      = (ram_cnt_reg != '0) && (ob_demand < 3'd2);
  assign ob_wr_slot = ((ob_cnt_reg - 2'(pop_fire)) != 2'd0);

  assign bus.push_ready = ram_has_room;
  assign bus.full       = !ram_has_room;
  assign bus.pop_valid  = ob_has_data;
  assign bus.pop_data   = ob_data_reg[0];
  assign bus.count      = count_reg;
  assign bus.empty      = (count_reg == '0);

  // RAM array: write port plus registered read port, contents never reset.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      ram_mem[wr_ptr_reg] <= bus.push_data;
    end
    if (issue) begin
      ram_rd_data_reg <= ram_mem[rd_ptr_reg];
    end
  end

  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    ram_cnt_next     = ram_cnt_reg + (ADDRW + 1)'(push_fire) - (ADDRW + 1)'(issue);
    rd_inflight_next = issue;
    ob_cnt_next      = ob_cnt_reg - 2'(pop_fire) + 2'(rd_inflight_reg);
    ob_data_next[0]  = ob_data_reg[0];
    ob_data_next[1]  = ob_data_reg[1];

    if (push_fire) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (issue) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (pop_fire) begin
      ob_data_next[0] = ob_data_reg[1];
    end
    // Returning data lands behind whatever survives this cycle's pop.
    if (rd_inflight_reg) begin
      if (ob_wr_slot) begin
        ob_data_next[1] = ram_rd_data_reg;
      end else begin
        ob_data_next[0] = ram_rd_data_reg;
      end
    end

    count_next = CNTW'(ram_cnt_next) + CNTW'(rd_inflight_next) + CNTW'(ob_cnt_next);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      ram_cnt_reg     <= '0;
      rd_inflight_reg <= 1'b0;
      ob_cnt_reg      <= 2'd0;
      ob_data_reg[0]  <= '0;
      ob_data_reg[1]  <= '0;
      count_reg       <= '0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      ram_cnt_reg     <= ram_cnt_next;
      rd_inflight_reg <= rd_inflight_next;
      ob_cnt_reg      <= ob_cnt_next;
      ob_data_reg[0]  <= ob_data_next[0];
      ob_data_reg[1]  <= ob_data_next[1];
      count_reg       <= count_next;
    end
  end

  a_ram_bound: assert property (@(posedge clk) disable iff (!reset_n)
    ram_cnt_reg <= RAM_FULL);
  a_ob_bound: assert property (@(posedge clk) disable iff (!reset_n)
    ob_cnt_reg <= 2'd2);
  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    count_reg <= COUNT_MAX);
endmodule
